// File: rtl/adc_pacer_pkg.sv
// Shared constants for the ADC sample pacer: register offsets, STATUS/CTRL
// bit positions and ADC full-scale codes.
package adc_pacer_pkg;

   // Register offsets relative to the block base address
   localparam logic [31:0] CTRL_OFS    = 32'h00;
   localparam logic [31:0] PACE_OFS    = 32'h04;
   localparam logic [31:0] STATUS_OFS  = 32'h08;
   localparam logic [31:0] DROPCNT_OFS = 32'h0C;
   localparam logic [31:0] SATCNT_OFS  = 32'h10;

   // CTRL bits
   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;

   // STATUS bits
   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_LVL_LSB = 4;
   localparam int ST_LVL_MSB = 8;
   localparam int ST_LVL_W   = ST_LVL_MSB - ST_LVL_LSB + 1;

   // ADC full-scale codes
   localparam logic [15:0] ADC_POS_FS = 16'h7FFF;
   localparam logic [15:0] ADC_NEG_FS = 16'h8000;

   // True when a sample sits at either rail
   function automatic logic is_full_scale(input logic [15:0] s);
      return (s == ADC_POS_FS) || (s == ADC_NEG_FS);
   endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Single-clock sample FIFO. Pointers carry one extra wrap bit so that
// level = wr - rd is exact and full/empty need no extra state.
module adc_sample_fifo #(
   parameter int DEPTH = 16,
   parameter int DW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DW-1:0]            din,
   output logic [DW-1:0]            dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [LW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [DW-1:0] mem_q [DEPTH];

   assign level = wr_q - rd_q;
   assign empty = (wr_q == rd_q);
   assign full  = (level == LW'(DEPTH));
   assign dout  = mem_q[rd_q[AW-1:0]];

   // Pointer next-state; flush returns both pointers to zero
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push) wr_d = wr_q + LW'(1);
         if (pop)  rd_d = rd_q + LW'(1);
      end
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Sample storage; a write into the head slot while full is safe because
   // the popped head is captured downstream on the same edge
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/adc_sample_pacer.sv
// ADC sample pacer: buffers raw ADC samples and replays them as the
// ADC/PushADC stream with a programmable minimum spacing between pushes.
// Optional feature macro: ADC_SAT_COUNT_EN adds the SATCNT full-scale counter.
module adc_sample_pacer
   import adc_pacer_pkg::*;
#(
   parameter int          DEPTH     = 16,
   parameter int          PACE_W    = 16,
   parameter logic [31:0] BASE_ADDR = 32'hFE000010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] Wdata,
   input  logic        write,
   input  logic        read,
   output logic [31:0] Rdata,
   input  logic [15:0] AdcIn,
   input  logic        AdcInValid,
   output logic [15:0] ADC,
   output logic        PushADC,
   output logic        AdcOverflow
);

   localparam int LW = $clog2(DEPTH) + 1;

   // Register decode
   logic sel_ctrl, sel_pace, sel_status, sel_drop;
   assign sel_ctrl   = (addr == BASE_ADDR + CTRL_OFS);
   assign sel_pace   = (addr == BASE_ADDR + PACE_OFS);
   assign sel_status = (addr == BASE_ADDR + STATUS_OFS);
   assign sel_drop   = (addr == BASE_ADDR + DROPCNT_OFS);

   logic en_q, en_d, ovf_q, ovf_d, push_q, push_d;
   logic [PACE_W-1:0] pace_q, pace_d, cnt_q, cnt_d;
   logic [31:0]       drop_q, drop_d;
   logic [15:0]       adc_q, adc_d;

   logic          fifo_full, fifo_empty;
   logic [15:0]   fifo_dout;
   logic [LW-1:0] fifo_level;

   logic flush, pop, accept, drop;

   // Flush overrides everything this cycle: no pop, incoming sample discarded
   assign flush  = write && sel_ctrl && Wdata[CTRL_FLUSH];
   assign pop    = en_q && !fifo_empty && (cnt_q == '0) && !flush;
   assign accept = AdcInValid && en_q && !flush && (!fifo_full || pop);
   assign drop   = AdcInValid && en_q && !flush && fifo_full && !pop;

   adc_sample_fifo #(.DEPTH(DEPTH), .DW(16)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .flush (flush),
      .din   (AdcIn),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Register file, pace counter and output next-state; bus clears beat status sets
   always_comb begin
      en_d   = en_q;
      pace_d = pace_q;
      ovf_d  = ovf_q;
      drop_d = drop_q;
      cnt_d  = cnt_q;
      adc_d  = adc_q;
      push_d = pop;

      if (write && sel_ctrl) en_d   = Wdata[CTRL_EN];
      if (write && sel_pace) pace_d = Wdata[PACE_W-1:0];

      if (write && sel_status && Wdata[ST_OVF]) ovf_d = 1'b0;
      else if (drop)                            ovf_d = 1'b1;

      if (write && sel_drop)              drop_d = '0;
      else if (drop && (drop_q != '1))    drop_d = drop_q + 32'd1;

      if (flush)            cnt_d = '0;
      else if (pop)         cnt_d = pace_q;
      else if (cnt_q != '0) cnt_d = cnt_q - PACE_W'(1);

      if (pop) adc_d = fifo_dout;
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q   <= 1'b0;
         pace_q <= '0;
         ovf_q  <= 1'b0;
         drop_q <= '0;
         cnt_q  <= '0;
         adc_q  <= '0;
         push_q <= 1'b0;
      end else begin
         en_q   <= en_d;
         pace_q <= pace_d;
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
         cnt_q  <= cnt_d;
         adc_q  <= adc_d;
         push_q <= push_d;
      end
   end

`ifdef ADC_SAT_COUNT_EN
   logic        sel_sat;
   logic [31:0] sat_q, sat_d;
   assign sel_sat = (addr == BASE_ADDR + SATCNT_OFS);

   // Count accepted rail samples, saturating; any write clears
   always_comb begin
      sat_d = sat_q;
      if (write && sel_sat)                                         sat_d = '0;
      else if (accept && is_full_scale(AdcIn) && (sat_q != '1))     sat_d = sat_q + 32'd1;
   end

   // Saturation counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sat_q <= '0;
      else      sat_q <= sat_d;
   end
`endif

   // Combinational read mux; unmapped addresses and idle bus read 0
   always_comb begin
      Rdata = '0;
      if (read) begin
         if (sel_ctrl)   Rdata[CTRL_EN]     = en_q;
         if (sel_pace)   Rdata[PACE_W-1:0]  = pace_q;
         if (sel_status) begin
            Rdata[ST_EMPTY]               = fifo_empty;
            Rdata[ST_FULL]                = fifo_full;
            Rdata[ST_OVF]                 = ovf_q;
            Rdata[ST_LVL_MSB:ST_LVL_LSB]  = ST_LVL_W'(fifo_level);
         end
         if (sel_drop)   Rdata = drop_q;
`ifdef ADC_SAT_COUNT_EN
         if (sel_sat)    Rdata = sat_q;
`endif
      end
   end

   assign ADC         = adc_q;
   assign PushADC     = push_q;
   assign AdcOverflow = ovf_q;

endmodule

// File: tb/tb_adc_sample_pacer.sv
// Self-checking bench for adc_sample_pacer: queue-based reference model,
// per-cycle output compare, directed scenarios plus randomized traffic.
module tb_adc_sample_pacer;

   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'hFE000010;

   logic        clk = 0, rst = 0;
   logic [31:0] addr = 0, Wdata = 0, Rdata;
   logic        write = 0, read = 0;
   logic [15:0] AdcIn = 0, ADC;
   logic        AdcInValid = 0, PushADC, AdcOverflow;

   adc_sample_pacer #(.DEPTH(DEPTH), .PACE_W(16), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write), .read(read),
      .Rdata(Rdata), .AdcIn(AdcIn), .AdcInValid(AdcInValid), .ADC(ADC),
      .PushADC(PushADC), .AdcOverflow(AdcOverflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] q[$];
   int          m_cnt, m_pace;
   bit          m_en, m_ovf, e_push;
   logic [31:0] m_drop, m_sat;
   logic [15:0] e_adc;

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      logic [31:0] r;
      r = 0;
      if (a == BASE + 32'h0)       r = {31'b0, m_en};
      else if (a == BASE + 32'h4)  r = m_pace;
      else if (a == BASE + 32'h8)  r = (q.size() << 4) | (m_ovf << 2)
                                       | ((q.size() == DEPTH) << 1) | (q.size() == 0);
      else if (a == BASE + 32'hC)  r = m_drop;
`ifdef ADC_SAT_COUNT_EN
      else if (a == BASE + 32'h10) r = m_sat;
`endif
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin : mdl
      bit fl, pp, ac, dr, fu;
      if (!rst) begin
         q.delete();
         m_cnt = 0; m_pace = 0; m_en = 0; m_ovf = 0; m_drop = 0; m_sat = 0;
         e_adc = 0; e_push = 0;
      end else begin
         cyc++;
         fl = write && addr == BASE && Wdata[1];
         fu = q.size() == DEPTH;
         pp = m_en && q.size() > 0 && m_cnt == 0 && !fl;
         ac = AdcInValid && m_en && !fl && (!fu || pp);
         dr = AdcInValid && m_en && !fl && fu && !pp;
         e_push = pp;
         if (pp) e_adc = q.pop_front();
         if (fl) q.delete();
         if (ac) begin
            q.push_back(AdcIn);
            if ((AdcIn == 16'h7FFF || AdcIn == 16'h8000) && m_sat != 32'hFFFFFFFF) m_sat++;
         end
         if (fl) m_cnt = 0;
         else if (pp) m_cnt = m_pace;
         else if (m_cnt > 0) m_cnt--;
         if (write && addr == BASE + 32'h10) m_sat = 0;
         if (write && addr == BASE + 32'h8 && Wdata[2]) m_ovf = 0;
         else if (dr) m_ovf = 1;
         if (write && addr == BASE + 32'hC) m_drop = 0;
         else if (dr && m_drop != 32'hFFFFFFFF) m_drop++;
         if (write && addr == BASE) m_en = Wdata[0];
         if (write && addr == BASE + 32'h4) m_pace = int'(Wdata[15:0]);
      end
   end

   // ---------------- per-cycle compare ----------------
   int          pc[$];
   logic [15:0] pv[$];
   always @(negedge clk) begin
      chk("ADC", {16'b0, ADC}, {16'b0, e_adc});
      chk("PushADC", {31'b0, PushADC}, {31'b0, e_push});
      chk("AdcOverflow", {31'b0, AdcOverflow}, {31'b0, m_ovf});
      if (PushADC) begin
         pc.push_back(cyc);
         pv.push_back(ADC);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [31:0] ofs, input logic [31:0] d,
                         input bit v = 0, input logic [15:0] s = 0);
      addr = BASE + ofs; Wdata = d; write = 1; AdcInValid = v; AdcIn = s;
      tick();
      write = 0; AdcInValid = 0;
   endtask

   task automatic smp(input logic [15:0] s);
      AdcIn = s; AdcInValid = 1;
      tick();
      AdcInValid = 0;
   endtask

   task automatic rd_lit(input logic [31:0] ofs, input logic [31:0] exp, input string nm);
      addr = BASE + ofs; read = 1;
      #1;
      chk(nm, Rdata, exp);
      chk({nm, "_model"}, Rdata, model_rd(addr));
      read = 0;
   endtask

   initial begin
      int c0, n;
      tick(3);
      rst = 1;
      tick();
      // reset state
      rd_lit(32'h8, 32'h1, "rst_status");
      rd_lit(32'hC, 32'h0, "rst_dropcnt");
      rd_lit(32'h0, 32'h0, "rst_ctrl");
      chk("rst_adc", {16'b0, ADC}, 32'h0);

      // back-to-back stream, PACE=0
      bus_wr(32'h0, 32'h1);
      bus_wr(32'h4, 32'h0);
      pc.delete(); pv.delete();
      c0 = cyc + 1;
      smp(16'd1); smp(16'd2); smp(16'd3);
      tick(3);
      chk("p0_npush", pc.size(), 3);
      if (pc.size() == 3) begin
         chk("p0_first_cyc", pc[0], c0 + 1);
         chk("p0_last_cyc", pc[2], c0 + 3);
         chk("p0_v0", {16'b0, pv[0]}, 32'd1);
         chk("p0_v2", {16'b0, pv[2]}, 32'd3);
      end

      // PACE=3 with four samples queued behind a dummy
      bus_wr(32'h4, 32'h3);
      smp(16'h00AA);
      smp(16'd10); smp(16'd11); smp(16'd12); smp(16'd13);
      rd_lit(32'h8, 32'h40, "p3_level4");
      pc.delete(); pv.delete();
      for (int i = 0; i < 16; i++) begin
         addr = BASE + 32'h8; read = 1; #1;
         chk("p3_status", Rdata, model_rd(addr));
         read = 0;
         tick();
      end
      chk("p3_npush", pc.size(), 4);
      if (pc.size() == 4)
         for (int i = 0; i < 4; i++) begin
            chk("p3_val", {16'b0, pv[i]}, 32'd10 + i);
            if (i > 0) chk("p3_spacing", pc[i] - pc[i-1], 4);
         end
      rd_lit(32'h8, 32'h1, "p3_empty");

      // overflow: 18 samples into a stalled 16-deep FIFO
      bus_wr(32'hC, 32'h0);
      bus_wr(32'h4, 32'hFFFF);
      smp(16'h00BB);
      tick();
      for (int i = 0; i < 18; i++) smp(16'd100 + 16'(i));
      rd_lit(32'h8, 32'h106, "ovf_status");
      rd_lit(32'hC, 32'h2, "ovf_dropcnt");
      chk("ovf_flag", {31'b0, AdcOverflow}, 32'h1);
      bus_wr(32'h8, 32'h4);
      rd_lit(32'h8, 32'h102, "ovf_cleared_status");
      rd_lit(32'hC, 32'h2, "ovf_cleared_dropcnt");
      chk("ovf_flag_clr", {31'b0, AdcOverflow}, 32'h0);

      // flush with a same-cycle sample at level 5
      bus_wr(32'h0, 32'h3);
      smp(16'h00CC);
      tick();
      for (int i = 0; i < 5; i++) smp(16'd200 + 16'(i));
      rd_lit(32'h8, 32'h50, "fl_level5");
      n = pc.size();
      bus_wr(32'h0, 32'h3, 1, 16'h0055);
      rd_lit(32'h8, 32'h1, "fl_status");
      rd_lit(32'hC, 32'h2, "fl_dropcnt");
      tick();
      chk("fl_nopush", pc.size(), n);
      bus_wr(32'h4, 32'h0);
      smp(16'h0077);
      tick(2);
      chk("fl_after_npush", pc.size(), n + 1);
      if (pc.size() == n + 1) chk("fl_after_val", {16'b0, pv[n]}, 32'h77);

`ifdef ADC_SAT_COUNT_EN
      bus_wr(32'h10, 32'h0);
      smp(16'h7FFF); smp(16'h8000); smp(16'h0001);
      tick(3);
      rd_lit(32'h10, 32'h2, "satcnt");
`else
      bus_wr(32'h10, 32'hFFFF_FFFF);
      rd_lit(32'h10, 32'h0, "satcnt_unmapped");
`endif
      rd_lit(32'h14, 32'h0, "unmapped_14");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r, ofs;
         r = int'($urandom_range(0, 7));
         AdcIn = (r == 0) ? 16'h7FFF : (r == 1) ? 16'h8000 : 16'($urandom);
         AdcInValid = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 6))
            0: ofs = 0;  1: ofs = 4;  2: ofs = 8;  3: ofs = 12;
            4: ofs = 16; 5: ofs = 20; default: ofs = 3;
         endcase
         addr = BASE + 32'(ofs);
         write = ($urandom_range(0, 15) == 0);
         case (ofs)
            0:       Wdata = {30'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0)};
            4:       Wdata = 32'($urandom_range(0, 5));
            default: Wdata = $urandom;
         endcase
         read = ($urandom_range(0, 3) != 0);
         #1;
         chk("rand_rd", Rdata, read ? model_rd(addr) : 32'h0);
         tick();
         write = 0; read = 0;
      end
      AdcInValid = 0;
      tick(2);

      // reset mid-stream
      AdcInValid = 1; AdcIn = 16'h1234;
      #2 rst = 0;
      #1;
      chk("mrst_adc", {16'b0, ADC}, 32'h0);
      chk("mrst_push", {31'b0, PushADC}, 32'h0);
      rd_lit(32'h8, 32'h1, "mrst_status");
      rd_lit(32'hC, 32'h0, "mrst_dropcnt");
      tick();
      rst = 1;
      AdcInValid = 0;
      tick(3);
      rd_lit(32'h8, 32'h1, "post_rst_status");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
